// File: rtl/sipo_shifter.sv
// sipo_shifter -- serial-in / parallel-out capture stage.
//
// Takes the registered serial bit stream from the upstream dffs cell and
// assembles WIDTH-bit words framed by FS. Completed words are presented on
// Q (true) and QN (complement) with a level-valid QV held until ACK. A word
// that completes while the previous one is still unacknowledged is dropped
// and raises the sticky OVR flag.
//
// Optional build macro: SIPO_PARITY_EN
//   When defined, each word is followed by one odd-parity bit (PAR state),
//   completion moves to the parity-bit edge, and PERR reports a mismatch.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
//   LSB_FIRST  0: first received bit lands in Q[WIDTH-1]; 1: in Q[0]
//
// Ports:
//   CK    in   clock, rising edge
//   RN    in   asynchronous active-low reset
//   D     in   serial data bit
//   DV    in   serial bit valid
//   FS    in   frame start (bit 0 of a new word, only with DV=1)
//   ACK   in   consumer accepts the word on Q
//   CLR   in   synchronous clear of OVR
//   Q     out  assembled word
//   QN    out  complement of Q
//   QV    out  word valid, held until ACK
//   OVR   out  sticky overrun flag
//   BUSY  out  high while a word is being assembled
//   PERR  out  parity mismatch for the word on Q (SIPO_PARITY_EN only)

module sipo_shifter #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             D,
  input  logic             DV,
  input  logic             FS,
  input  logic             ACK,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             QV,
  output logic             OVR,
`ifdef SIPO_PARITY_EN
  output logic             PERR,
`endif
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
    ,PAR  = 2'd2
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   sr, sr_nxt;
  logic [WIDTH-1:0]   word;
  logic               done;
  logic [WIDTH-1:0]   q_r;
  logic               qv_r;
  logic               ovr_r;
  logic               perr_nxt;
  logic               perr_r;

  // Register image holding only the first bit of a new word.
  function automatic logic [WIDTH-1:0] first_bit(input logic d);
    logic [WIDTH-1:0] r;
    r = '0;
    if (LSB_FIRST != 0) r[WIDTH-1] = d;
    else                r[0]       = d;
    return r;
  endfunction

  // Shift direction chosen so the first bit ends up at the configured end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                input logic d);
    logic [WIDTH-1:0] r;
    if (LSB_FIRST != 0) r = {d, s[WIDTH-1:1]};
    else                r = {s[WIDTH-2:0], d};
    return r;
  endfunction

  // Stage: frame state, bit counter and shift register
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    word      = sr;
    done      = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        // A bit without FS carries no framing and is discarded.
        if (DV && FS) begin
          sr_nxt    = first_bit(D);
          cnt_nxt   = CNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (DV) begin
          if (FS) begin
            // FS wins even on the last bit: restart, never complete.
            sr_nxt  = first_bit(D);
            cnt_nxt = CNT_W'(1);
          end else begin
            sr_nxt = shift_in(sr, D);
            if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              cnt_nxt   = CNT_W'(WIDTH);
              state_nxt = PAR;
`else
              done      = 1'b1;
              word      = sr_nxt;
              cnt_nxt   = '0;
              state_nxt = IDLE;
`endif
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PAR: begin
        if (DV) begin
          if (FS) begin
            sr_nxt    = first_bit(D);
            cnt_nxt   = CNT_W'(1);
            state_nxt = SHIFT;
          end else begin
            // Odd parity: data ones plus the parity bit must be odd.
            done      = 1'b1;
            word      = sr;
            perr_nxt  = ~(^sr ^ D);
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage: output word, valid/ACK handshake and overrun flag
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      q_r    <= '0;
      qv_r   <= 1'b0;
      ovr_r  <= 1'b0;
      perr_r <= 1'b0;
    end else begin
      // A completion on the ACK edge replaces the accepted word directly.
      if (done && (!qv_r || ACK)) begin
        q_r    <= word;
        qv_r   <= 1'b1;
        perr_r <= perr_nxt;
      end else if (ACK) begin
        qv_r <= 1'b0;
      end
      // A new overrun outranks CLR on the same edge.
      if (done && qv_r && !ACK) ovr_r <= 1'b1;
      else if (CLR)             ovr_r <= 1'b0;
    end
  end

  assign Q    = q_r;
  assign QN   = ~q_r;
  assign QV   = qv_r;
  assign OVR  = ovr_r;
`ifdef SIPO_PARITY_EN
  assign PERR = perr_r;
  assign BUSY = (state == SHIFT) || (state == PAR);
`else
  assign BUSY = (state == SHIFT);
`endif

endmodule

// File: tb/tb_sipo_shifter.sv
module tb_sipo_shifter;

  logic       CK, RN, D, DV, FS, ACK, CLR;
  logic [7:0] Q0, QN0, Q1, QN1;
  logic       QV0, OVR0, BUSY0, QV1, OVR1, BUSY1;
`ifdef SIPO_PARITY_EN
  logic       PERR0, PERR1;
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  sipo_shifter #(.WIDTH(8), .LSB_FIRST(0)) dut0 (
    .CK(CK), .RN(RN), .D(D), .DV(DV), .FS(FS), .ACK(ACK), .CLR(CLR),
    .Q(Q0), .QN(QN0), .QV(QV0), .OVR(OVR0),
`ifdef SIPO_PARITY_EN
    .PERR(PERR0),
`endif
    .BUSY(BUSY0));

  sipo_shifter #(.WIDTH(8), .LSB_FIRST(1)) dut1 (
    .CK(CK), .RN(RN), .D(D), .DV(DV), .FS(FS), .ACK(ACK), .CLR(CLR),
    .Q(Q1), .QN(QN1), .QV(QV1), .OVR(OVR1),
`ifdef SIPO_PARITY_EN
    .PERR(PERR1),
`endif
    .BUSY(BUSY1));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       perr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] w;
    int         gap;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t tbl[6];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Output monitor: a word is produced when QV rises, or when QV stays high
  // across an ACK edge (accepted word replaced by a new one).
  logic mon_pq, mon_pa;
  always @(posedge CK) begin
    mon_pq = QV0;
    mon_pa = ACK;
    #1;
    if (RN && QV0 && (!mon_pq || mon_pa)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", Q0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_q_msb", 32'(Q0), 32'(e.q0));
        chk("sb_q_lsb", 32'(Q1), 32'(e.q1));
        chk("sb_qv_lsb", 32'(QV1), 32'(1'b1));
`ifdef SIPO_PARITY_EN
        chk("sb_perr", 32'(PERR0), 32'(e.perr));
`endif
      end
    end
  end

  task automatic step(input logic d, input logic dv, input logic fs,
                      input logic ack, input logic clr);
    D = d; DV = dv; FS = fs; ACK = ack; CLR = clr;
    @(posedge CK);
    #1;
    D = 1'b0; DV = 1'b0; FS = 1'b0; ACK = 1'b0; CLR = 1'b0;
  endtask

  // Sends w MSB first (plus odd parity when enabled). e1 is the word the
  // LSB_FIRST instance must show.
  task automatic send_word(input logic [7:0] w, input logic [7:0] e1,
                           input int gap, input bit push, input bit chkq,
                           input bit ack_last, input bit clr_last,
                           input bit bad_par);
    logic b;
    bit   last;
    for (int i = 0; i < NB; i++) begin
      last = (i == NB - 1);
      if (i > 0) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      b = (i < 8) ? w[7 - i] : (~(^w) ^ bad_par);
      if (last && push) sb.push_back('{w, e1, bad_par});
      step(b, 1'b1, (i == 0), last ? ack_last : 1'b0, last ? clr_last : 1'b0);
      if (!last && chkq) begin
        chk("qv_early", 32'(QV0), 32'(1'b0));
        chk("busy_mid", 32'(BUSY0), 32'(1'b1));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_q"},    32'(Q0),    32'h00);
    chk({tag, "_qn"},   32'(QN0),   32'hFF);
    chk({tag, "_qv"},   32'(QV0),   32'(1'b0));
    chk({tag, "_ovr"},  32'(OVR0),  32'(1'b0));
    chk({tag, "_busy"}, 32'(BUSY0), 32'(1'b0));
    chk({tag, "_q1"},   32'(Q1),    32'h00);
  endtask

  initial begin
    tbl[0] = '{8'hB2, 0, 8'hB2, 8'h4D};
    tbl[1] = '{8'hB2, 3, 8'hB2, 8'h4D};
    tbl[2] = '{8'h00, 0, 8'h00, 8'h00};
    tbl[3] = '{8'hFF, 1, 8'hFF, 8'hFF};
    tbl[4] = '{8'h01, 0, 8'h01, 8'h80};
    tbl[5] = '{8'h3C, 2, 8'h3C, 8'h3C};

    RN = 1'b0; D = 1'b0; DV = 1'b0; FS = 1'b0; ACK = 1'b0; CLR = 1'b0;
    #12;
    chk_reset_outputs("rst_init");
    @(posedge CK); #1;
    RN = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-word after three bits.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_before_rst", 32'(BUSY0), 32'(1'b1));
    RN = 1'b0;
    #2;
    chk_reset_outputs("rst_mid");
    @(posedge CK); #1;
    RN = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Bits without FS after release must not resume the lost word.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_no_frame_qv", 32'(QV0), 32'(1'b0));
    chk("idle_no_frame_busy", 32'(BUSY0), 32'(1'b0));

    // Table-driven frames, each acknowledged one cycle later.
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].w, tbl[i].e1, tbl[i].gap, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("tbl_qv",   32'(QV0),   32'(1'b1));
      chk("tbl_q",    32'(Q0),    32'(tbl[i].e0));
      chk("tbl_qn",   32'(QN0),   32'(8'(~tbl[i].e0)));
      chk("tbl_busy", 32'(BUSY0), 32'(1'b0));
      chk("tbl_q1",   32'(Q1),    32'(tbl[i].e1));
      chk("tbl_qn1",  32'(QN1),   32'(8'(~tbl[i].e1)));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("tbl_ack_qv",   32'(QV0), 32'(1'b0));
      chk("tbl_ack_hold", 32'(Q0),  32'(tbl[i].e0));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("tbl_ack_idle", 32'(QV0), 32'(1'b0));
    end

    // Restart: five bits, then FS with a fresh A5 frame.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, (i == 0), 1'b0, 1'b0);
      chk("restart_qv_low", 32'(QV0), 32'(1'b0));
    end
    send_word(8'hA5, 8'hA5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_q",   32'(Q0),   32'hA5);
    chk("restart_ovr", 32'(OVR0), 32'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart on the eighth bit is not a completion.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i == 0), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("fs_last_qv",   32'(QV0),   32'(1'b0));
    chk("fs_last_busy", 32'(BUSY0), 32'(1'b1));
    send_word(8'h5A, 8'h5A, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fs_last_q", 32'(Q0), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: 11 delivered, 22 dropped.
    send_word(8'h11, 8'h88, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_q",    32'(Q0),   32'h11);
    chk("ovr_q1",   32'(Q1),   32'h88);
    chk("ovr_qv",   32'(QV0),  32'(1'b1));
    chk("ovr_flag", 32'(OVR0), 32'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_ack_qv",  32'(QV0),  32'(1'b0));
    chk("ovr_sticky",  32'(OVR0), 32'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(OVR0), 32'(1'b0));

    // Completion on the ACK edge: new word replaces old, no overrun.
    send_word(8'h33, 8'hCC, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h44, 8'h22, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ackc_q",   32'(Q0),   32'h44);
    chk("ackc_qv",  32'(QV0),  32'(1'b1));
    chk("ackc_ovr", 32'(OVR0), 32'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // CLR on the same edge as a new overrun: set wins.
    send_word(8'h55, 8'hAA, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h66, 8'h66, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_vs_set_ovr", 32'(OVR0), 32'(1'b1));
    chk("clr_vs_set_q",   32'(Q0),   32'h55);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_final", 32'(OVR0), 32'(1'b0));

`ifdef SIPO_PARITY_EN
    send_word(8'hB2, 8'h4D, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("par_ok_perr", 32'(PERR0), 32'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hB2, 8'h4D, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("par_bad_perr", 32'(PERR0), 32'(1'b1));
    chk("par_bad_q",    32'(Q0),    32'hB2);
    chk("par_bad_qv",   32'(QV0),   32'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_shifter.md
Name: sipo_shifter

Overview:
- Serial-in/parallel-out capture stage. It sits directly downstream of the dffs cell and consumes the registered serial bit stream on that cell's Q output.
- Assembles WIDTH-bit words under frame-start control.
- Presents each word with true and complement outputs (Q/QN style) and a level-valid/ACK handshake to the consumer.
- Flags overrun when the consumer falls behind.

Parameters:
- WIDTH, 8, data bits per word (2..32).
- LSB_FIRST, 0. 0 = first received bit lands in Q[WIDTH-1]; 1 = first received bit lands in Q[0].

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- D  input  1  serial data bit, sampled only when DV=1.
- DV  input  1  serial bit valid qualifier.
- FS  input  1  frame start; qualifies the bit on D as bit 0 of a new word (ignored when DV=0).
- ACK  input  1  consumer accepts the word held on Q.
- CLR  input  1  synchronous clear of OVR.
- Q  output  WIDTH  assembled word.
- QN  output  WIDTH  bitwise complement of Q, always.
- QV  output  1  word valid, held until ACK.
- OVR  output  1  sticky overrun flag.
- BUSY  output  1  high while in state SHIFT.

Behaviour:
- Reset (RN=0, asynchronous, no clock needed):
  - State=IDLE; bit counter=0; shift register=0.
  - Q=0, QN=all ones, QV=0, OVR=0, BUSY=0.
  - Release is synchronous to the next rising CK edge.
  - Reset mid-word discards the partial word.
- States: IDLE, SHIFT (plus PAR when the optional feature is enabled).
- IDLE:
  - DV=1 & FS=1: capture D as bit 0; count=1; go to SHIFT.
  - DV=1 & FS=0: ignored (no framing).
  - DV=0: hold.
- SHIFT:
  - DV=1 & FS=0: shift in D; count+1.
  - DV=1 & FS=1: abort the partial word; capture D as new bit 0; count=1; stay in SHIFT. No QV and no OVR are generated for the aborted word.
  - DV=0: hold state and count; gaps of any length are allowed.
- Word completion:
  - Occurs on the edge that samples bit WIDTH-1 (count reaches WIDTH).
  - Next state is IDLE.
  - Edge case WIDTH-th bit with FS=1 is treated as a restart, not a completion.
- Completion latency: on that same edge, Q/QN load the word and QV goes 1. Zero extra cycles after the last bit; the word is visible after the edge.
- Handshake:
  - QV stays 1 until an edge with ACK=1; that edge clears QV.
  - ACK while QV=0 has no effect.
  - Q holds its value after ACK (not cleared).
- Simultaneous completion & ACK on the same edge: the old word is accepted, the new word loads, and QV stays 1. OVR is not set.
- Completion while QV=1 & ACK=0:
  - The new word is dropped; Q keeps the old word.
  - OVR is set to 1 (sticky).
  - QV stays 1.
- OVR clear:
  - Cleared by RN, or by an edge with CLR=1.
  - CLR and a new overrun on the same edge: set wins.
- Counter width: ceil(log2(WIDTH+1)) bits; no wrap, since it is reset to 0 on return to IDLE.
- QN is derived as ~Q (combinational), so it is never inconsistent with Q.
- BUSY=1 exactly in SHIFT (and PAR).
- Unreachable state encodings recover to IDLE.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - After bit WIDTH-1 the FSM enters PAR and expects one more DV bit: an odd-parity bit over the WIDTH data bits.
  - Completion occurs on the parity-bit edge; latency is +1 DV bit.
  - Added output port PERR (1 bit): loaded together with QV, 1 = parity mismatch. It is cleared when a new word loads or on reset.
  - The word is delivered even when PERR=1.
  - FS=1 in PAR restarts the word exactly as in SHIFT.
- Undefined: no PAR state and no PERR port; completion occurs on the data bit WIDTH-1.

Test Plan:
- Reset: drive RN=0 mid-word after 3 bits, then release and send a full frame → outputs are Q=8'h00, QN=8'hFF, QV=0, OVR=0 during reset; after release the next frame is assembled correctly with no leftover bits.
- Basic frame, WIDTH=8, LSB_FIRST=0: FS on the first bit, D sequence 1,0,1,1,0,0,1,0 with DV=1 every cycle → Q=8'hB2 and QN=8'h4D on the 8th edge, QV=1, BUSY falls; ACK one cycle later → QV=0 and Q still 8'hB2.
- DV gaps, LSB_FIRST=1: same bits with DV=0 gaps of 3 cycles between bits → Q=8'h4D; QV rises only on the edge of the 8th valid bit.
- Restart: send 5 bits, then FS=1 with a new frame 8'hA5 (MSB first) → Q=8'hA5, a single QV pulse, OVR=0.
- Overrun: deliver 8'h11 with no ACK, then deliver 8'h22 → Q stays 8'h11, OVR=1; ACK → QV=0, OVR still 1; CLR → OVR=0. Also check completion with ACK on the same edge: Q=new word, QV stays 1, OVR=0.
- With SIPO_PARITY_EN: send 8'hB2 followed by parity bit 1 → PERR=0; repeat with parity bit 0 → PERR=1 and Q=8'hB2 delivered.
